// File: rtl/pipeline_pkg.sv
// Shared types for the unified memory port: port state and transaction owner tags.
package pipeline_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF   = 2'd0,
    OWN_DM   = 2'd1,
    OWN_DROP = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks the single outstanding memory access: latency down-counter and owner tag.
//   state | meaning
//   IDLE  | port free, nothing in flight
//   BUSY  | access in flight; cnt counts LAT down to 1 (response cycle)
module mem_resp_tracker
  import pipeline_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [1:0] owner_in,
  input  logic       flush,
  output logic       busy,
  output logic       resp_cycle,
  output logic [1:0] owner
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  owner_t           owner_q;

  assign busy       = (state_q == BUSY);
  assign resp_cycle = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  assign owner      = owner_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
    end else if (issue) begin
      state_q <= BUSY;
      cnt_q   <= CNT_W'(LAT);
      owner_q <= owner_t'(owner_in);
    end else if (state_q == BUSY) begin
      if (resp_cycle) state_q <= IDLE;
      else            cnt_q   <= cnt_q - CNT_W'(1);
      // A flushed fetch keeps the port busy but its data is thrown away.
      if (flush && (owner_q == OWN_IF)) owner_q <= OWN_DROP;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between fetch and the MEM stage,
// with data priority, a fetch starvation guard and flush of in-flight fetches.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int LAT    = 1,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rden,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  logic          busy, resp_cycle;
  logic [1:0]    owner, owner_in;
  logic          if_elig, dm_elig, can_issue, if_win, dm_win, issue;
  logic [SW-1:0] starve_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  assign if_valid = resp_cycle && (owner == OWN_IF) && !if_flush;
  assign dm_valid = resp_cycle && (owner == OWN_DM);

  // A requester being answered this cycle still presents its old request.
  assign if_elig   = if_req && !if_flush && !(resp_cycle && (owner == OWN_IF));
  assign dm_elig   = dm_req && !(resp_cycle && (owner == OWN_DM));
  assign can_issue = rst && (!busy || resp_cycle);
  assign if_win    = can_issue && if_elig && (!dm_elig || (starve_q >= SW'(STARVE)));
  assign dm_win    = can_issue && dm_elig && !if_win;
  assign issue     = if_win || dm_win;
  assign owner_in  = if_win ? OWN_IF : OWN_DM;

  assign mem_rden  = if_win || (dm_win && !dm_we);
  assign mem_wren  = dm_win && dm_we;
  assign mem_addr  = if_win ? if_addr : (dm_win ? dm_addr : '0);
  assign mem_wdata = mem_wren ? dm_wdata : '0;

  assign if_rdata = if_valid ? mem_q : if_rdata_q;
  assign dm_rdata = (dm_valid && !dm_we) ? mem_q : dm_rdata_q;
  assign stall_if = if_req && !if_valid && !if_flush;
  assign stall_dm = dm_req && !dm_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_valid)              if_rdata_q <= mem_q;
      if (dm_valid && !dm_we)    dm_rdata_q <= mem_q;
      if (!if_req || if_win)     starve_q   <= '0;
      else if (dm_win && if_elig && (starve_q < SW'(STARVE)))
        starve_q <= starve_q + SW'(1);
    end
  end

  mem_resp_tracker #(.LAT(LAT)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .owner_in   (owner_in),
    .flush      (if_flush),
    .busy       (busy),
    .resp_cycle (resp_cycle),
    .owner      (owner)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LAT=1 and LAT=3 instances, vector table, corner sequences, random vs model.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst;
  logic          ir [2], fl [2], dr [2], dw [2];
  logic [AW-1:0] ia [2], da [2];
  logic [DW-1:0] dd [2];
  logic          iv [2], dv [2], si [2], sd [2], rd [2], wr [2];
  logic [DW-1:0] ifr [2], dmr [2], md [2], mq [2];
  logic [AW-1:0] ma [2];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1), .STARVE(STARVE)) u_lat1 (
    .clk(clk), .rst(rst), .if_req(ir[0]), .if_addr(ia[0]), .if_flush(fl[0]),
    .if_valid(iv[0]), .if_rdata(ifr[0]), .dm_req(dr[0]), .dm_we(dw[0]),
    .dm_addr(da[0]), .dm_wdata(dd[0]), .dm_valid(dv[0]), .dm_rdata(dmr[0]),
    .stall_if(si[0]), .stall_dm(sd[0]), .mem_addr(ma[0]), .mem_wdata(md[0]),
    .mem_rden(rd[0]), .mem_wren(wr[0]), .mem_q(mq[0]));

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(3), .STARVE(STARVE)) u_lat3 (
    .clk(clk), .rst(rst), .if_req(ir[1]), .if_addr(ia[1]), .if_flush(fl[1]),
    .if_valid(iv[1]), .if_rdata(ifr[1]), .dm_req(dr[1]), .dm_we(dw[1]),
    .dm_addr(da[1]), .dm_wdata(dd[1]), .dm_valid(dv[1]), .dm_rdata(dmr[1]),
    .stall_if(si[1]), .stall_dm(sd[1]), .mem_addr(ma[1]), .mem_wdata(md[1]),
    .mem_rden(rd[1]), .mem_wren(wr[1]), .mem_q(mq[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA000_0000 | DW'(a));
  endfunction

  // Memory models: contents reload on reset, read data emerges LAT cycles after the strobe.
  logic [DW-1:0] phys [2][1024];
  logic [DW-1:0] line1;
  logic [DW-1:0] line3 [3];

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 1024; a++) phys[k][a] <= init_word(a);
    end else begin
      for (int k = 0; k < 2; k++)
        if (wr[k]) phys[k][ma[k]] <= md[k];
    end
    line1    <= rd[0] ? phys[0][ma[0]] : $urandom;
    line3[0] <= rd[1] ? phys[1][ma[1]] : $urandom;
    line3[1] <= line3[0];
    line3[2] <= line3[1];
  end

  assign mq[0] = line1;
  assign mq[1] = line3[2];

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_in(input int k);
    ir[k] = 1'b0; fl[k] = 1'b0; dr[k] = 1'b0; dw[k] = 1'b0;
    ia[k] = '0;   da[k] = '0;   dd[k] = '0;
  endtask

  task automatic drive(input int k, input logic [31:0] r_ir, r_ia, r_fl, r_dr, r_dw, r_da, r_dd);
    @(negedge clk);
    ir[k] = r_ir[0]; ia[k] = r_ia[AW-1:0]; fl[k] = r_fl[0];
    dr[k] = r_dr[0]; dw[k] = r_dw[0]; da[k] = r_da[AW-1:0]; dd[k] = r_dd;
    #2;
  endtask

  task automatic chk_zero(input int k, input string nm);
    chkb({nm, ".if_valid"}, iv[k], 1'b0);
    chkb({nm, ".dm_valid"}, dv[k], 1'b0);
    chkb({nm, ".stalls"}, si[k] | sd[k], 1'b0);
    chkb({nm, ".strobes"}, rd[k] | wr[k], 1'b0);
    chkw({nm, ".rdata"}, ifr[k] | dmr[k], 32'h0);
    chkw({nm, ".mem_bus"}, 32'(ma[k]) | md[k], 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; idle_in(0); idle_in(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
  endtask

  typedef struct {
    logic [31:0] ir, ia, fl, dr, dw, da, dd;
    logic [31:0] rd, wr, ma, iv, dv, si, sd, rdat;
  } vec_t;

  vec_t tv [28];

  function automatic vec_t v(input logic [31:0] a_ir, a_ia, a_fl, a_dr, a_dw, a_da, a_dd,
                             input logic [31:0] e_rd, e_wr, e_ma, e_iv, e_dv, e_si, e_sd, e_r);
    vec_t r;
    r.ir = a_ir; r.ia = a_ia; r.fl = a_fl; r.dr = a_dr; r.dw = a_dw; r.da = a_da; r.dd = a_dd;
    r.rd = e_rd; r.wr = e_wr; r.ma = e_ma; r.iv = e_iv; r.dv = e_dv; r.si = e_si; r.sd = e_sd;
    r.rdat = e_r;
    return r;
  endfunction

  // Reference model state for the random phase (times are absolute cycle numbers).
  int            m_resp [2];
  int            m_own [2];   // 0 none, 1 fetch, 2 data, 3 dropped fetch
  bit            m_st [2];
  int            m_starve [2];
  logic [DW-1:0] m_pend [2], m_lif [2], m_ldm [2];
  logic [DW-1:0] refm [2][1024];
  bit            if_act [2], dm_act [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_resp[k] = -1; m_own[k] = 0; m_st[k] = 1'b0; m_starve[k] = 0;
      m_pend[k] = '0; m_lif[k] = '0; m_ldm[k] = '0;
      if_act[k] = 1'b0; dm_act[k] = 1'b0;
      for (int a = 0; a < 1024; a++) refm[k][a] = init_word(a);
    end
  endtask

  task automatic model_step(input int k, input int cyc);
    bit            resp, e_iv, e_dv, if_ok, dm_ok, g_if, g_dm;
    logic [AW-1:0] addr;
    logic [DW-1:0] e_ifr, e_dmr;
    string         tag;
    resp  = (m_resp[k] == cyc);
    e_iv  = resp && (m_own[k] == 1) && !fl[k];
    e_dv  = resp && (m_own[k] == 2);
    if_ok = ir[k] && !fl[k] && !(resp && (m_own[k] == 1));
    dm_ok = dr[k] && !(resp && (m_own[k] == 2));
    g_if  = (m_resp[k] <= cyc) && if_ok && (!dm_ok || (m_starve[k] >= STARVE));
    g_dm  = (m_resp[k] <= cyc) && dm_ok && !g_if;
    addr  = g_if ? ia[k] : da[k];
    e_ifr = e_iv ? m_pend[k] : m_lif[k];
    e_dmr = (e_dv && !m_st[k]) ? m_pend[k] : m_ldm[k];
    tag   = $sformatf("rnd.L%0d.c%0d", lat_of(k), cyc);
    chkb({tag, ".rden"}, rd[k], g_if || (g_dm && !dw[k]));
    chkb({tag, ".wren"}, wr[k], g_dm && dw[k]);
    if (g_if || g_dm) chkw({tag, ".mem_addr"}, 32'(ma[k]), 32'(addr));
    if (g_dm && dw[k]) chkw({tag, ".mem_wdata"}, md[k], dd[k]);
    chkb({tag, ".if_valid"}, iv[k], e_iv);
    chkb({tag, ".dm_valid"}, dv[k], e_dv);
    chkw({tag, ".if_rdata"}, ifr[k], e_ifr);
    chkw({tag, ".dm_rdata"}, dmr[k], e_dmr);
    chkb({tag, ".stall_if"}, si[k], ir[k] && !e_iv && !fl[k]);
    chkb({tag, ".stall_dm"}, sd[k], dr[k] && !e_dv);
    m_lif[k] = e_ifr;
    m_ldm[k] = e_dmr;
    if (fl[k] && (m_own[k] == 1)) m_own[k] = 3;
    if (g_if || g_dm) begin
      m_resp[k] = cyc + lat_of(k);
      m_own[k]  = g_if ? 1 : 2;
      m_st[k]   = g_dm && dw[k];
      if (m_st[k]) refm[k][addr] = dd[k];
      else         m_pend[k]     = refm[k][addr];
    end
    if (!ir[k] || g_if) m_starve[k] = 0;
    else if (g_dm && if_ok && (m_starve[k] < STARVE)) m_starve[k]++;
    if (e_iv || fl[k]) if_act[k] = 1'b0;
    if (e_dv) dm_act[k] = 1'b0;
  endtask

  initial begin
    int nw, nv;
    rst = 1'b0;
    idle_in(0);
    idle_in(1);

    //          ir ia    fl dr dw da     dd            rd wr ma     iv dv si sd rdata
    tv[0]  = v(1, 5,    0, 0, 0, 0,     0,            1, 0, 5,     0, 0, 1, 0, 0);
    tv[1]  = v(1, 5,    0, 0, 0, 0,     0,            0, 0, 0,     1, 0, 0, 0, 32'hDEADBEEF);
    tv[2]  = v(1, 6,    0, 0, 0, 0,     0,            1, 0, 6,     0, 0, 1, 0, 0);
    tv[3]  = v(1, 6,    0, 0, 0, 0,     0,            0, 0, 0,     1, 0, 0, 0, 32'hA0000006);
    tv[4]  = v(0, 0,    0, 0, 0, 0,     0,            0, 0, 0,     0, 0, 0, 0, 0);
    tv[5]  = v(1, 7,    0, 1, 0, 'h20,  0,            1, 0, 'h20,  0, 0, 1, 1, 0);
    tv[6]  = v(1, 7,    0, 1, 0, 'h20,  0,            1, 0, 7,     0, 1, 1, 0, 32'hA0000020);
    tv[7]  = v(1, 7,    0, 0, 0, 0,     0,            0, 0, 0,     1, 0, 0, 0, 32'hA0000007);
    tv[8]  = v(0, 0,    0, 0, 0, 0,     0,            0, 0, 0,     0, 0, 0, 0, 0);
    tv[9]  = v(0, 0,    0, 1, 1, 'hFF,  32'h12345678, 0, 1, 'hFF,  0, 0, 0, 1, 0);
    tv[10] = v(0, 0,    0, 1, 1, 'hFF,  32'h12345678, 0, 0, 0,     0, 1, 0, 0, 32'hA0000020);
    tv[11] = v(0, 0,    0, 1, 0, 'hFF,  0,            1, 0, 'hFF,  0, 0, 0, 1, 0);
    tv[12] = v(0, 0,    0, 1, 0, 'hFF,  0,            0, 0, 0,     0, 1, 0, 0, 32'h12345678);
    tv[13] = v(0, 0,    0, 0, 0, 0,     0,            0, 0, 0,     0, 0, 0, 0, 0);
    tv[14] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 'h30,  0, 0, 1, 1, 0);
    tv[15] = v(1, 9,    1, 1, 0, 'h30,  0,            0, 0, 0,     0, 1, 0, 0, 32'hA0000030);
    tv[16] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 'h30,  0, 0, 1, 1, 0);
    tv[17] = tv[15];
    tv[18] = tv[16];
    tv[19] = tv[15];
    tv[20] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 9,     0, 0, 1, 1, 0);
    tv[21] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 'h30,  1, 0, 0, 1, 32'hA0000009);
    tv[22] = v(0, 0,    0, 1, 0, 'h30,  0,            0, 0, 0,     0, 1, 0, 0, 32'hA0000030);
    tv[23] = v(0, 0,    0, 0, 0, 0,     0,            0, 0, 0,     0, 0, 0, 0, 0);
    tv[24] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 'h30,  0, 0, 1, 1, 0);
    tv[25] = v(1, 9,    0, 1, 0, 'h30,  0,            1, 0, 9,     0, 1, 1, 0, 32'hA0000030);
    tv[26] = v(1, 9,    0, 0, 0, 0,     0,            0, 0, 0,     1, 0, 0, 0, 32'hA0000009);
    tv[27] = v(0, 0,    0, 0, 0, 0,     0,            0, 0, 0,     0, 0, 0, 0, 0);

    do_reset();
    chk_zero(0, "reset.L1");
    chk_zero(1, "reset.L3");

    for (int i = 0; i < 28; i++) begin
      drive(0, tv[i].ir, tv[i].ia, tv[i].fl, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
      chkb($sformatf("v%0d.rden", i), rd[0], tv[i].rd[0]);
      chkb($sformatf("v%0d.wren", i), wr[0], tv[i].wr[0]);
      chkb($sformatf("v%0d.if_valid", i), iv[0], tv[i].iv[0]);
      chkb($sformatf("v%0d.dm_valid", i), dv[0], tv[i].dv[0]);
      chkb($sformatf("v%0d.stall_if", i), si[0], tv[i].si[0]);
      chkb($sformatf("v%0d.stall_dm", i), sd[0], tv[i].sd[0]);
      if (tv[i].rd[0] || tv[i].wr[0]) chkw($sformatf("v%0d.mem_addr", i), 32'(ma[0]), tv[i].ma);
      if (tv[i].wr[0]) chkw($sformatf("v%0d.mem_wdata", i), md[0], tv[i].dd);
      if (tv[i].iv[0]) chkw($sformatf("v%0d.if_rdata", i), ifr[0], tv[i].rdat);
      if (tv[i].dv[0]) chkw($sformatf("v%0d.dm_rdata", i), dmr[0], tv[i].rdat);
    end

    // LAT=3: fetch flushed while in flight, pending load takes the port in the response cycle.
    drive(1, 1, 'h11, 0, 0, 0, 0, 0);
    chkb("flush.issue_rden", rd[1], 1'b1);
    chkw("flush.issue_addr", 32'(ma[1]), 32'h11);
    drive(1, 1, 'h11, 1, 1, 0, 'h40, 0);
    chkb("flush.busy_rden", rd[1], 1'b0);
    chkb("flush.stall_dm", sd[1], 1'b1);
    drive(1, 0, 0, 0, 1, 0, 'h40, 0);
    chkb("flush.t2_rden", rd[1], 1'b0);
    drive(1, 0, 0, 0, 1, 0, 'h40, 0);
    chkb("flush.no_if_valid", iv[1], 1'b0);
    chkb("flush.dm_issue", rd[1], 1'b1);
    chkw("flush.dm_addr", 32'(ma[1]), 32'h40);
    nv = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 0, 'h40, 0);
      nv += int'(dv[1]) + int'(iv[1]);
    end
    drive(1, 0, 0, 0, 1, 0, 'h40, 0);
    chkw("flush.early_valids", nv, 0);
    chkb("flush.dm_valid", dv[1], 1'b1);
    chkw("flush.dm_rdata", dmr[1], 32'hA0000040);
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // LAT=3 store: one write strobe, completion after LAT, load data unchanged.
    nw = 0;
    drive(1, 0, 0, 0, 1, 1, 'hFF, 32'h12345678);
    nw += int'(wr[1]);
    chkw("store.addr", 32'(ma[1]), 32'hFF);
    chkw("store.wdata", md[1], 32'h12345678);
    chkb("store.no_rden", rd[1], 1'b0);
    nv = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 1, 'hFF, 32'h12345678);
      nw += int'(wr[1]);
      nv += int'(dv[1]);
    end
    drive(1, 0, 0, 0, 1, 1, 'hFF, 32'h12345678);
    nw += int'(wr[1]);
    chkw("store.early_valid", nv, 0);
    chkb("store.dm_valid", dv[1], 1'b1);
    chkw("store.rdata_kept", dmr[1], 32'hA0000040);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    nw += int'(wr[1]);
    chkw("store.wren_cycles", nw, 1);

    // LAT=3 reset while cnt=2: transaction abandoned, then a clean fetch.
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    chkb("rstmid.issue", rd[1], 1'b1);
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; idle_in(0); idle_in(1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_zero(1, "rstmid.after");
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      nv += int'(iv[1]) + int'(dv[1]);
    end
    chkw("rstmid.late_valids", nv, 0);
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    chkb("rstmid.refetch_rden", rd[1], 1'b1);
    chkw("rstmid.refetch_addr", 32'(ma[1]), 32'h5);
    nv = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5, 0, 0, 0, 0, 0);
      nv += int'(iv[1]);
    end
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    chkw("rstmid.early_if_valid", nv, 0);
    chkb("rstmid.if_valid", iv[1], 1'b1);
    chkw("rstmid.if_rdata", ifr[1], 32'hDEADBEEF);

    // Random protocol-respecting traffic on both instances against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!if_act[k] && ($urandom_range(0, 1) == 1)) begin
          if_act[k] = 1'b1;
          ia[k] = ($urandom_range(0, 9) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 15));
        end
        ir[k] = if_act[k];
        fl[k] = if_act[k] && ($urandom_range(0, 7) == 0);
        if (!dm_act[k] && ($urandom_range(0, 2) != 0)) begin
          dm_act[k] = 1'b1;
          dw[k] = ($urandom_range(0, 2) == 0);
          da[k] = ($urandom_range(0, 9) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 15));
          dd[k] = $urandom;
        end
        dr[k] = dm_act[k];
      end
      #2;
      for (int k = 0; k < 2; k++) model_step(k, cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage and the MEM stage of the 5-stage pipeline.
- Arbitrates requests, sequences the fixed-latency memory port, and returns data with a valid pulse.
- Produces stall qualifiers so that fetch and MEM hold until served.
- Honours the branch-flush signal for in-flight fetches.

Parameters:
- AW, 10, word-address width (PC and data addresses are zero-extended to AW).
- DW, 32, data width.
- LAT, 1, memory read latency in cycles (legal 1..7).
- STARVE, 3, max consecutive data grants while a fetch waits before a fetch grant is forced.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request, held until if_valid or flush.
- if_addr  in  AW  fetch word address, stable while if_req is high.
- if_flush  in  1  branch flush; cancels pending or in-flight fetch.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DW  fetched instruction.
- dm_req  in  1  data request (rden | wren), held until dm_valid.
- dm_we  in  1  1 = store, 0 = load; stable with dm_req.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_valid  out  1  one-cycle pulse: load data valid or store complete.
- dm_rdata  out  DW  load data.
- stall_if  out  1  if_req & ~if_valid & ~if_flush.
- stall_dm  out  1  dm_req & ~dm_valid.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rden  out  1  memory read strobe.
- mem_wren  out  1  memory write strobe.
- mem_q  in  DW  memory read data, valid LAT cycles after the strobe.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; counter, starvation count and in-flight tag are cleared.
  - All outputs read 0 in the following cycle.
  - A transaction in flight is abandoned and no valid is produced.
- States:
  - IDLE: port free.
  - BUSY: cnt counts LAT down to 1; owner tag is IF, DM or DROP.
- Issue:
  - Issue happens in IDLE, or in BUSY when cnt==1 (the response cycle doubles as an issue cycle, giving full throughput at LAT=1).
  - mem_* are driven combinationally from the winner in the issue cycle only.
  - mem_rden = winner is a load or a fetch; mem_wren = winner is a store.
  - In every other cycle all strobes are 0; mem_addr and mem_wdata are don't-care.
- Eligibility:
  - A requester whose response is in the current cycle is not eligible this cycle; its req still shows the old address.
  - A fetch with if_flush=1 in that cycle is not eligible.
- Priority:
  - DM wins when both requesters are eligible.
  - Exception: if the starvation count is ≥ STARVE and IF is eligible, IF wins.
- Starvation counter:
  - Increments on each DM grant made while IF is eligible.
  - Clears on an IF grant or when if_req=0.
  - Saturates at STARVE.
- Transitions:
  - Issue → BUSY with cnt=LAT.
  - cnt>1 → cnt-1.
  - cnt==1 with no new issue → IDLE.
- Response:
  - In the cycle cnt==1, the owner gets its valid pulse.
  - rdata = mem_q, passed through combinationally and held as registered last value otherwise.
  - Stores pulse dm_valid with dm_rdata unchanged.
- Flush:
  - if_flush while the owner is IF changes the tag to DROP.
  - The memory stays busy until cnt==1; no if_valid is produced.
  - if_flush in the response cycle itself suppresses if_valid.
  - if_flush never affects DM.
- Invariants:
  - At most one valid pulse per cycle.
  - if_valid and dm_valid are never both 1.
  - Strobes are never asserted in non-issue cycles.

Decomposition:
- Shared package pipeline_pkg:
  - state enum {IDLE, BUSY}.
  - owner enum {OWN_IF, OWN_DM, OWN_DROP}.
  - localparam CNT_W = 3.
- Sub-module mem_resp_tracker: latency counter plus owner tag, with inputs issue, owner_in and flush, and outputs resp_cycle and owner.
- Arbitration and the starvation counter stay in the top module.

Test Plan:
- LAT=1, if_req only, if_addr=0x005, mem returns 0xDEADBEEF:
  - mem_rden at T; if_valid=1 with if_rdata=0xDEADBEEF at T+1.
  - Next address is issued in the cycle after.
- Both requests at T, dm_we=0, dm_addr=0x020:
  - DM is served first (dm_valid at T+1).
  - Fetch is issued at T+1 (response cycle) and valid at T+2.
  - stall_if stays high through T+1.
- Starvation, STARVE=3, dm_req held for back-to-back loads and if_req held:
  - Grants are DM, DM, DM, then IF.
  - Counter is cleared after the IF grant.
- Flush, LAT=3: fetch issued at T, if_flush pulsed at T+1:
  - No if_valid at T+3.
  - Pending DM is issued at T+3.
- Store, dm_we=1, dm_addr=0x0FF, dm_wdata=0x12345678:
  - mem_wren for exactly one cycle with matching address and data.
  - dm_valid after LAT cycles; dm_rdata unchanged.
- Reset mid-transaction, rst=0 while cnt=2 at LAT=3:
  - All outputs are 0 next cycle; no valid is emitted later.
  - A new fetch after release behaves as in scenario 1.
